// File: rtl/lwc_ctrl_pkg.sv
// Shared types and constants for the LWC AEAD controller: FSM states,
// ctrl_word codes, the AD block type and the partial-word byte mask.
package lwc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_KEY, S_LOAD_NPUB, S_INIT, S_WAIT_INIT,
        S_LOAD_BLK, S_BLK_START, S_BLK_WAIT, S_OUT_BLK,
        S_TAG_START, S_LOAD_TAG, S_TAG_WAIT, S_OUT_TAG, S_VERIFY
    } state_t;

    localparam logic [1:0] CW_INIT = 2'b00;
    localparam logic [1:0] CW_AD   = 2'b01;
    localparam logic [1:0] CW_MSG  = 2'b10;
    localparam logic [1:0] CW_FIN  = 2'b11;

    localparam logic [3:0] AD_TYPE = 4'b0001;

    // Top `size` bits of an nb-bit field set; the MSB is the first byte on the bus.
    function automatic logic [7:0] vb_mask(input int unsigned size, input int unsigned nb);
        int unsigned sz;
        int unsigned v;
        sz = (size > nb) ? nb : size;
        v  = ((32'd1 << sz) - 32'd1) << (nb - sz);
        return v[7:0];
    endfunction

endpackage

// File: rtl/lwc_word_ctr.sv
// Word-slot counter with clear, load and increment, plus a compare against
// a caller-supplied terminal count.
module lwc_word_ctr #(
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [IW-1:0] load_val,
    input  logic          inc,
    input  logic [IW-1:0] tc,
    output logic [IW-1:0] count,
    output logic          at_tc
);

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       count <= '0;
        else if (clr)  count <= '0;
        else if (load) count <= load_val;
        else if (inc)  count <= count + 1'b1;
    end

    assign at_tc = (count == tc);

endmodule

// File: rtl/lwc_aead_ctrl.sv
// LWC AEAD control FSM: sequences key/nonce load, init, AD and message
// blocks, tag generation and tag verification around the permutation.
module lwc_aead_ctrl
    import lwc_ctrl_pkg::*;
#(
    parameter  int W           = 32,
    parameter  int KEY_WORDS   = 4,
    parameter  int NPUB_WORDS  = 4,
    parameter  int BLOCK_WORDS = 2,
    parameter  int TAG_WORDS   = 4,
    localparam int NB          = W / 8,
    localparam int SW          = $clog2(NB) + 1,
    localparam int MAXW_A      = (KEY_WORDS > NPUB_WORDS) ? KEY_WORDS : NPUB_WORDS,
    localparam int MAXW_B      = (BLOCK_WORDS > TAG_WORDS) ? BLOCK_WORDS : TAG_WORDS,
    localparam int MAXW        = (MAXW_A > MAXW_B) ? MAXW_A : MAXW_B,
    localparam int IW          = (MAXW > 1) ? $clog2(MAXW) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    output logic          key_ready,
    input  logic          key_update,
    input  logic          bdi_valid,
    output logic          bdi_ready,
    input  logic          bdi_eot,
    input  logic          bdi_eoi,
    input  logic [3:0]    bdi_type,
    input  logic [SW-1:0] bdi_size,
    input  logic          decrypt,
    output logic          bdo_valid,
    input  logic          bdo_ready,
    output logic [NB-1:0] bdo_valid_bytes,
    output logic          end_of_block,
    output logic          msg_auth_valid,
    input  logic          msg_auth_ready,
    input  logic          perm_done,
    output logic          start,
    output logic          en_key,
    output logic          en_npub,
    output logic          en_bdi,
    output logic          clr_bdi,
    output logic          init_state,
    output logic          en_state,
    output logic          sel_tag,
    output logic [1:0]    ctrl_word,
    output logic [IW-1:0] word_idx,
    output logic          decrypt_reg,
    output logic          ad_reg
);

    state_t        state, state_nxt;
    logic [IW-1:0] idx, tc, blk_last;
    logic          at_tc, ctr_clr, ctr_inc;
    logic          eoi_flag, eot_flag, perm_flag;
    logic [SW-1:0] last_size;
    logic [7:0]    last_mask;

    lwc_word_ctr #(.IW(IW)) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (ctr_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (ctr_inc),
        .tc       (tc),
        .count    (idx),
        .at_tc    (at_tc)
    );

    assign word_idx  = idx;
    assign last_mask = vb_mask(32'(last_size), NB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decrypt_reg <= 1'b0;
            ad_reg      <= 1'b0;
            eoi_flag    <= 1'b0;
            eot_flag    <= 1'b0;
            last_size   <= '0;
            blk_last    <= '0;
            perm_flag   <= 1'b0;
        end else begin
            // Completion latched so it may land while expected-tag words stream in.
            if (state == S_IDLE) perm_flag <= 1'b0;
            else if (perm_done)  perm_flag <= 1'b1;
            else if (start)      perm_flag <= 1'b0;

            case (state)
                S_IDLE: begin
                    eoi_flag <= 1'b0;
                    eot_flag <= 1'b0;
                end
                S_LOAD_NPUB: if (bdi_valid && at_tc) begin
                    decrypt_reg <= decrypt;
                    eoi_flag    <= bdi_eoi;
                end
                S_LOAD_BLK: if (bdi_valid) begin
                    last_size <= bdi_size;
                    if (idx == '0) ad_reg <= (bdi_type == AD_TYPE);
                    if (bdi_eot || at_tc) begin
                        blk_last <= idx;
                        eot_flag <= bdi_eot;
                        eoi_flag <= bdi_eoi;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_nxt       = state;
        key_ready       = 1'b0;
        bdi_ready       = 1'b0;
        bdo_valid       = 1'b0;
        bdo_valid_bytes = '1;
        end_of_block    = 1'b0;
        msg_auth_valid  = 1'b0;
        start           = 1'b0;
        en_key          = 1'b0;
        en_npub         = 1'b0;
        en_bdi          = 1'b0;
        clr_bdi         = 1'b0;
        init_state      = 1'b0;
        en_state        = 1'b0;
        sel_tag         = 1'b0;
        ctrl_word       = CW_INIT;
        ctr_clr         = 1'b0;
        ctr_inc         = 1'b0;
        tc              = '0;

        case (state)
            S_IDLE: begin
                ctr_clr = 1'b1;
                if (key_update && key_valid)      state_nxt = S_LOAD_KEY;
                else if (!key_update && bdi_valid) state_nxt = S_LOAD_NPUB;
            end
            S_LOAD_KEY: begin
                key_ready = 1'b1;
                tc        = IW'(KEY_WORDS - 1);
                if (key_valid) begin
                    en_key = 1'b1;
                    if (at_tc) begin ctr_clr = 1'b1; state_nxt = S_LOAD_NPUB; end
                    else ctr_inc = 1'b1;
                end
            end
            S_LOAD_NPUB: begin
                bdi_ready = 1'b1;
                tc        = IW'(NPUB_WORDS - 1);
                if (bdi_valid) begin
                    en_npub = 1'b1;
                    if (at_tc) begin ctr_clr = 1'b1; state_nxt = S_INIT; end
                    else ctr_inc = 1'b1;
                end
            end
            S_INIT: begin
                start      = 1'b1;
                init_state = 1'b1;
                state_nxt  = S_WAIT_INIT;
            end
            S_WAIT_INIT: if (perm_flag) begin
                en_state = 1'b1;
                if (eoi_flag) state_nxt = S_TAG_START;
                else begin clr_bdi = 1'b1; state_nxt = S_LOAD_BLK; end
            end
            S_LOAD_BLK: begin
                bdi_ready = 1'b1;
                tc        = IW'(BLOCK_WORDS - 1);
                if (bdi_valid) begin
                    en_bdi = 1'b1;
                    if (bdi_eot || at_tc) begin ctr_clr = 1'b1; state_nxt = S_BLK_START; end
                    else ctr_inc = 1'b1;
                end
            end
            S_BLK_START: begin
                start     = 1'b1;
                ctrl_word = ad_reg ? CW_AD : CW_MSG;
                state_nxt = S_BLK_WAIT;
            end
            S_BLK_WAIT: if (perm_flag) begin
                if (ad_reg) begin
                    en_state  = 1'b1;
                    ctrl_word = CW_AD;
                    if (eoi_flag) state_nxt = S_TAG_START;
                    else begin clr_bdi = 1'b1; state_nxt = S_LOAD_BLK; end
                end else begin
                    state_nxt = S_OUT_BLK;
                end
            end
            S_OUT_BLK: begin
                bdo_valid = 1'b1;
                tc        = blk_last;
                if (at_tc) begin
                    bdo_valid_bytes = last_mask[NB-1:0];
                    end_of_block    = eot_flag;
                end
                if (bdo_ready) begin
                    if (at_tc) begin
                        en_state  = 1'b1;
                        ctrl_word = CW_MSG;
                        ctr_clr   = 1'b1;
                        if (eoi_flag) state_nxt = S_TAG_START;
                        else begin clr_bdi = 1'b1; state_nxt = S_LOAD_BLK; end
                    end else ctr_inc = 1'b1;
                end
            end
            S_TAG_START: begin
                start     = 1'b1;
                ctrl_word = CW_FIN;
                if (decrypt_reg) begin clr_bdi = 1'b1; state_nxt = S_LOAD_TAG; end
                else state_nxt = S_TAG_WAIT;
            end
            S_LOAD_TAG: begin
                bdi_ready = 1'b1;
                tc        = IW'(TAG_WORDS - 1);
                if (bdi_valid) begin
                    en_bdi = 1'b1;
                    if (at_tc) begin ctr_clr = 1'b1; state_nxt = S_TAG_WAIT; end
                    else ctr_inc = 1'b1;
                end
            end
            S_TAG_WAIT: if (perm_flag) begin
                en_state  = 1'b1;
                ctrl_word = CW_FIN;
                state_nxt = decrypt_reg ? S_VERIFY : S_OUT_TAG;
            end
            S_OUT_TAG: begin
                bdo_valid    = 1'b1;
                sel_tag      = 1'b1;
                tc           = IW'(TAG_WORDS - 1);
                end_of_block = at_tc;
                if (bdo_ready) begin
                    if (at_tc) begin ctr_clr = 1'b1; state_nxt = S_IDLE; end
                    else ctr_inc = 1'b1;
                end
            end
            S_VERIFY: begin
                msg_auth_valid = 1'b1;
                if (msg_auth_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The permutation never completes in the cycle that launches it.
    assert property (@(posedge clk) disable iff (rst) !(perm_done && start));

endmodule
